// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizes and width helper for the FIFO arbiters.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int DefNumReq = 4;
    localparam int DefMaxPkt = 16;

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from last_gnt+1 with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NumReq = DefNumReq,
    parameter int IdxW   = clog2w(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last_gnt,
    output logic              found,
    output logic [IdxW-1:0]   idx
);

    logic [IdxW-1:0] c;

    // Scan farthest-first so the nearest requester after last_gnt overwrites the result.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = '0;
        for (int k = NumReq; k >= 1; k--) begin
            c = IdxW'((int'(last_gnt) + k) % NumReq);
            if (req[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin arbiter driving the write port of fifo_async.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int Width  = 8,
    parameter int NumReq = DefNumReq,
    parameter int MaxPkt = DefMaxPkt,
    parameter int IdxW   = clog2w(NumReq)
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NumReq-1:0]       req_valid,
    input  logic [NumReq-1:0]       req_last,
    input  logic [NumReq*Width-1:0] req_data,
    output logic [NumReq-1:0]       req_ready,
    input  logic                    full,
    output logic                    w_en,
    output logic [Width-1:0]        data_in,
    output logic [IdxW-1:0]         grant_id,
    output logic                    busy,
    output logic                    pkt_err
);

    localparam int CntW = clog2w(MaxPkt + 1);

    state_e          state;
    logic [IdxW-1:0] gnt;
    logic [IdxW-1:0] last_gnt;
    logic [IdxW-1:0] pick;
    logic            found;
    logic [CntW-1:0] word_cnt;
    logic            acc;

    rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick (
        .req      (req_valid),
        .last_gnt (last_gnt),
        .found    (found),
        .idx      (pick)
    );

    assign busy      = (state == BUSY);
    assign grant_id  = gnt;
    assign acc       = busy && req_valid[gnt] && !full;
    assign w_en      = acc;
    assign req_ready = (busy && !full) ? NumReq'(1) << gnt : '0;
    assign data_in   = busy ? req_data[gnt*Width +: Width] : '0;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= IdxW'(NumReq - 1);
            word_cnt <= '0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    gnt      <= pick;
                    word_cnt <= '0;
                    state    <= BUSY;
                end
            end else if (acc) begin
                word_cnt <= word_cnt + 1'b1;
                // The length limit releases the lock; the rest of the packet re-arbitrates.
                if (req_last[gnt] || word_cnt == CntW'(MaxPkt - 1)) begin
                    last_gnt <= gnt;
                    state    <= IDLE;
                    pkt_err  <= !req_last[gnt];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios with per-requester sources and a write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_last = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          full = 1'b0;
    logic          w_en;
    logic [W-1:0]  data_in;
    logic [1:0]    grant_id;
    logic          busy;
    logic          pkt_err;

    logic [8:0]    srcq [N][$];
    logic [9:0]    sb [$];
    logic [N-1:0]  hold = '0;
    logic [N-1:0]  take = '0;
    int            vectors = 0;
    int            miscompares = 0;
    int            perr_cnt = 0;

    fifo_wr_arbiter #(.Width(W), .NumReq(N), .MaxPkt(16)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .w_en      (w_en),
        .data_in   (data_in),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_err   (pkt_err)
    );

    always #5 wclk = ~wclk;

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            h = (srcq[i].size() != 0) ? srcq[i][0] : 9'h0;
            req_valid[i]      = (srcq[i].size() != 0) && !hold[i];
            req_last[i]       = h[8];
            req_data[i*W +: W] = h[7:0];
        end
    endtask

    // Sources retire the words the DUT accepted on the previous edge.
    always @(posedge wclk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (take[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
        drive();
    end

    always @(negedge wclk) begin
        logic [9:0] e;
        for (int i = 0; i < N; i++) take[i] = req_valid[i] && req_ready[i];
        if (pkt_err) perr_cnt++;
        if (w_en) begin
            vectors++;
            assert (full === 1'b0) else begin
                miscompares++;
                $error("FAIL full_with_wen observed=%0b expected=0", full);
            end
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $error("FAIL sb_extra observed=%0h expected=none", {grant_id, data_in});
            end else begin
                e = sb.pop_front();
                assert ({grant_id, data_in} === e) else begin
                    miscompares++;
                    $error("FAIL sb_word observed=%0h expected=%0h", {grant_id, data_in}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge wclk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic src_pkt(input int id, input int n, input int base);
        for (int k = 0; k < n; k++) srcq[id].push_back({k == n - 1, 8'(base + k)});
    endtask

    task automatic exp_pkt(input int id, input int n, input int base);
        for (int k = 0; k < n; k++) sb.push_back({2'(id), 8'(base + k)});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        chk(tag, sb.size(), 0);
        step();
    endtask

    initial begin
        drive();
        repeat (2) step();
        chk("rst_wen", w_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", data_in, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", pkt_err, 0);
        wrst_n = 1'b1;
        step();

        // Single 3-word packet from requester 0.
        chk("t1_idle", busy, 0);
        src_pkt(0, 3, 8'hA1);
        exp_pkt(0, 3, 8'hA1);
        drive();
        step();
        chk("t1_busy", busy, 1);
        chk("t1_grant", grant_id, 0);
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_wen1", w_en, 1);
        step();
        chk("t1_wen2", w_en, 1);
        step();
        chk("t1_wen3", w_en, 1);
        step();
        chk("t1_done", {busy, w_en}, 0);
        drain("t1_drain");

        // Round robin with two 2-word packets per requester; last winner was 0.
        for (int i = 0; i < N; i++)
            for (int r = 0; r < 2; r++) src_pkt(i, 2, i * 16 + r * 4);
        for (int r = 0; r < 2; r++)
            for (int j = 1; j <= N; j++) exp_pkt(j % N, 2, (j % N) * 16 + r * 4);
        drive();
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("t2_wen%0d", k), w_en, (k % 3) != 0);
        end
        drain("t2_drain");

        // Full backpressure for 5 cycles in the middle of requester 2's packet.
        src_pkt(2, 6, 8'h20);
        exp_pkt(2, 6, 8'h20);
        drive();
        step();
        chk("t3_wen1", w_en, 1);
        step();
        chk("t3_wen2", w_en, 1);
        full = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_wen", w_en, 0);
            chk("t3_stall_ready", req_ready, 0);
            chk("t3_stall_grant", {busy, grant_id}, 3'b110);
        end
        full = 1'b0;
        drive();
        drain("t3_drain");

        // Requester 1 stalls mid-packet while requester 3 waits.
        src_pkt(1, 4, 8'h40);
        exp_pkt(1, 4, 8'h40);
        exp_pkt(3, 2, 8'h70);
        drive();
        step();
        chk("t4_wen1", w_en, 1);
        step();
        chk("t4_wen2", w_en, 1);
        hold[1] = 1'b1;
        src_pkt(3, 2, 8'h70);
        drive();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_stall_wen", w_en, 0);
            chk("t4_stall_grant", {busy, grant_id}, 3'b101);
            chk("t4_r3_ready", req_ready[3], 0);
        end
        hold[1] = 1'b0;
        drive();
        drain("t4_drain");

        // 20-word packet is cut after 16 words and the tail re-arbitrates.
        begin
            int p0 = perr_cnt;
            src_pkt(0, 20, 8'h80);
            exp_pkt(0, 20, 8'h80);
            drive();
            for (int k = 1; k <= 16; k++) begin
                step();
                chk("t5_wen", {w_en, pkt_err}, 2'b10);
            end
            step();
            chk("t5_release", {busy, w_en, pkt_err}, 3'b001);
            step();
            chk("t5_regrant", {busy, pkt_err, grant_id}, 4'b1000);
            drain("t5_drain");
            chk("t5_perr_once", perr_cnt - p0, 1);
        end

        // Reset after 2 of 4 words of requester 1's packet.
        src_pkt(1, 4, 8'hC0);
        exp_pkt(1, 2, 8'hC0);
        drive();
        step();
        chk("t6_grant", grant_id, 1);
        step();
        chk("t6_wen2", w_en, 1);
        step();
        wrst_n = 1'b0;
        #1;
        chk("t6_rst_wen", w_en, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_data", data_in, 0);
        chk("t6_rst_grant", grant_id, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_perr", pkt_err, 0);
        chk("t6_sb_flushed", sb.size(), 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        src_pkt(1, 1, 8'hD1);
        src_pkt(0, 1, 8'hD0);
        exp_pkt(0, 1, 8'hD0);
        exp_pkt(1, 1, 8'hD1);
        drive();
        step();
        wrst_n = 1'b1;
        step();
        chk("t6_first", {busy, grant_id}, 3'b100);
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
